// File: rtl/stb_pkg.sv
// Shared trace-buffer constants and the memory arbiter phase type.
package stb_pkg;

    localparam int unsigned TRB_DEPTH      = 8;
    localparam int unsigned TRB_WIDTH      = 8;
    localparam int unsigned TRB_ADDR_WIDTH = $clog2(TRB_DEPTH);

    typedef enum logic [1:0] {
        PH_LOG_WR = 2'd0,
        PH_LOG_RD = 2'd1,
        PH_HOST   = 2'd2
    } arb_phase_t;

endpackage

// File: rtl/trb_sdp_ram.sv
// Simple dual-port trace RAM: one write port, one registered read port,
// read-first on a same-cycle address collision.
module trb_sdp_ram #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     CLK_I,
    input  logic                     RST_I,
    input  logic                     WE_I,
    input  logic [$clog2(DEPTH)-1:0] WADDR_I,
    input  logic [WIDTH-1:0]         WDATA_I,
    input  logic [$clog2(DEPTH)-1:0] RADDR_I,
    output logic [WIDTH-1:0]         RDATA_O
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage is deliberately not reset.
    always_ff @(posedge CLK_I) begin
        if (WE_I) begin
            mem[WADDR_I] <= WDATA_I;
        end
    end

    // Non-blocking update makes a colliding read return the old word.
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            RDATA_O <= '0;
        end else begin
            RDATA_O <= mem[RADDR_I];
        end
    end

endmodule

// File: rtl/trb_mem_arbiter.sv
// Time-slices the trace RAM between the Logger (write slot, read slot)
// and an occasional host access slot.
module trb_mem_arbiter
    import stb_pkg::*;
#(
    parameter int unsigned DEPTH = TRB_DEPTH,
    parameter int unsigned WIDTH = TRB_WIDTH
) (
    input  logic                     CLK_I,
    input  logic                     RST_I,
    input  logic                     ENABLE_I,
    output logic                     LOG_RW_TURN_O,
    output logic                     LOG_WRITE_ALLOW_O,
    output logic                     LOG_READ_ALLOW_O,
    input  logic                     LOG_WRITE_I,
    input  logic [$clog2(DEPTH)-1:0] LOG_WRITE_PTR_I,
    input  logic [WIDTH-1:0]         LOG_DMEM_I,
    input  logic [$clog2(DEPTH)-1:0] LOG_READ_PTR_I,
    output logic [WIDTH-1:0]         LOG_DMEM_O,
    input  logic                     HOST_REQ_I,
    input  logic                     HOST_WE_I,
    input  logic [$clog2(DEPTH)-1:0] HOST_ADDR_I,
    input  logic [WIDTH-1:0]         HOST_WDATA_I,
    output logic                     HOST_ACK_O,
    output logic [WIDTH-1:0]         HOST_RDATA_O,
    input  logic                     HOST_FREEZE_I
);

    localparam int unsigned AW = $clog2(DEPTH);

    arb_phase_t       phase;
    arb_phase_t       phase_nxt;
    logic             rw_turn_c;
    logic             write_allow_c;
    logic             ram_we;
    logic [AW-1:0]    ram_waddr;
    logic [WIDTH-1:0] ram_wdata;
    logic [AW-1:0]    ram_raddr;
    logic [WIDTH-1:0] ram_q;
    logic             log_rd_vld;
    logic             host_rd_vld;
    logic             host_ack;

    assign rw_turn_c     = ENABLE_I && (phase == PH_LOG_WR);
    assign write_allow_c = ENABLE_I && !HOST_FREEZE_I;

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            phase <= PH_LOG_WR;
        end else begin
            phase <= phase_nxt;
        end
    end

    // Slot sequencing and RAM port steering.
    always_comb begin
        phase_nxt   = PH_LOG_WR;
        ram_we      = 1'b0;
        ram_waddr   = LOG_WRITE_PTR_I;
        ram_wdata   = LOG_DMEM_I;
        ram_raddr   = LOG_READ_PTR_I;
        log_rd_vld  = 1'b0;
        host_rd_vld = 1'b0;
        host_ack    = 1'b0;
        case (phase)
            PH_LOG_WR: begin
                phase_nxt = PH_LOG_RD;
                ram_we    = LOG_WRITE_I && rw_turn_c && write_allow_c;
            end
            PH_LOG_RD: begin
                phase_nxt  = HOST_REQ_I ? PH_HOST : PH_LOG_WR;
                ram_raddr  = HOST_ADDR_I;
                log_rd_vld = 1'b1;
            end
            PH_HOST: begin
                phase_nxt = PH_LOG_WR;
                ram_raddr = HOST_ADDR_I;
                host_ack  = 1'b1;
                if (HOST_WE_I) begin
                    ram_we    = 1'b1;
                    ram_waddr = HOST_ADDR_I;
                    ram_wdata = HOST_WDATA_I;
                end else begin
                    host_rd_vld = 1'b1;
                end
            end
            default: phase_nxt = PH_LOG_WR;
        endcase
        // A reset edge drops any in-flight slot: no write, no ACK.
        if (RST_I) begin
            ram_we      = 1'b0;
            log_rd_vld  = 1'b0;
            host_rd_vld = 1'b0;
            host_ack    = 1'b0;
        end
    end

    trb_sdp_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .CLK_I   (CLK_I),
        .RST_I   (RST_I),
        .WE_I    (ram_we),
        .WADDR_I (ram_waddr),
        .WDATA_I (ram_wdata),
        .RADDR_I (ram_raddr),
        .RDATA_O (ram_q)
    );

    assign LOG_RW_TURN_O     = rw_turn_c;
    assign LOG_WRITE_ALLOW_O = write_allow_c;
    assign LOG_READ_ALLOW_O  = ENABLE_I && (phase == PH_LOG_RD);
    assign LOG_DMEM_O        = log_rd_vld  ? ram_q : '0;
    assign HOST_RDATA_O      = host_rd_vld ? ram_q : '0;
    assign HOST_ACK_O        = host_ack;

endmodule

// File: tb/tb_trb_mem_arbiter.sv
// Self-checking bench for trb_mem_arbiter with a slot-level reference model.
module tb_trb_mem_arbiter;

    localparam int M_WR   = 0;
    localparam int M_RD   = 1;
    localparam int M_HOST = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       rw_turn, wallow, rallow;
    logic       log_wr;
    logic [2:0] log_wptr, log_rptr;
    logic [7:0] log_wdata, log_dmem;
    logic       host_req, host_we, host_ack, host_freeze;
    logic [2:0] host_addr;
    logic [7:0] host_wdata, host_rdata;

    int checks = 0;
    int errors = 0;

    // reference model state
    int         m_phase;
    logic [7:0] m_mem [8];
    bit         m_valid [8];
    logic [7:0] m_log_snap, m_host_snap;
    bit         m_log_ok, m_host_ok;

    // last observed outputs
    logic       last_rw, last_wallow, last_rallow, last_ack;
    logic [7:0] last_log, last_rdata;

    always #5 clk = ~clk;

    trb_mem_arbiter #(.DEPTH(8), .WIDTH(8)) dut (
        .CLK_I             (clk),
        .RST_I             (rst),
        .ENABLE_I          (en),
        .LOG_RW_TURN_O     (rw_turn),
        .LOG_WRITE_ALLOW_O (wallow),
        .LOG_READ_ALLOW_O  (rallow),
        .LOG_WRITE_I       (log_wr),
        .LOG_WRITE_PTR_I   (log_wptr),
        .LOG_DMEM_I        (log_wdata),
        .LOG_READ_PTR_I    (log_rptr),
        .LOG_DMEM_O        (log_dmem),
        .HOST_REQ_I        (host_req),
        .HOST_WE_I         (host_we),
        .HOST_ADDR_I       (host_addr),
        .HOST_WDATA_I      (host_wdata),
        .HOST_ACK_O        (host_ack),
        .HOST_RDATA_O      (host_rdata),
        .HOST_FREEZE_I     (host_freeze)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Check this cycle's outputs, then advance one clock and update the model.
    task automatic tick();
        bit   e_rw, e_rallow, e_ack;
        int   nph;
        #1;
        e_rw     = en && (m_phase == M_WR);
        e_rallow = en && (m_phase == M_RD);
        e_ack    = (m_phase == M_HOST) && !rst;
        chk("rw_turn", 32'(rw_turn), 32'(e_rw));
        chk("write_allow", 32'(wallow), 32'(en && !host_freeze));
        chk("read_allow", 32'(rallow), 32'(e_rallow));
        chk("host_ack", 32'(host_ack), 32'(e_ack));
        if (m_phase == M_RD && !rst) begin
            if (m_log_ok) chk("log_dmem", 32'(log_dmem), 32'(m_log_snap));
        end else begin
            chk("log_dmem_idle", 32'(log_dmem), 32'd0);
        end
        if (m_phase == M_HOST && !rst && !host_we) begin
            if (m_host_ok) chk("host_rdata", 32'(host_rdata), 32'(m_host_snap));
        end else begin
            chk("host_rdata_idle", 32'(host_rdata), 32'd0);
        end
        last_rw     = rw_turn;
        last_wallow = wallow;
        last_rallow = rallow;
        last_ack    = host_ack;
        last_log    = log_dmem;
        last_rdata  = host_rdata;

        @(posedge clk);
        #1;
        if (rst) begin
            nph = M_WR;
        end else begin
            case (m_phase)
                M_WR: begin
                    m_log_snap = m_mem[log_rptr];
                    m_log_ok   = m_valid[log_rptr];
                    if (log_wr && en && !host_freeze) begin
                        m_mem[log_wptr]   = log_wdata;
                        m_valid[log_wptr] = 1'b1;
                    end
                    nph = M_RD;
                end
                M_RD: begin
                    m_host_snap = m_mem[host_addr];
                    m_host_ok   = m_valid[host_addr];
                    nph = host_req ? M_HOST : M_WR;
                end
                default: begin
                    if (host_we) begin
                        m_mem[host_addr]   = host_wdata;
                        m_valid[host_addr] = 1'b1;
                    end
                    nph = M_WR;
                end
            endcase
        end
        m_phase = nph;
    endtask

    task automatic wait_phase(input int ph);
        int guard = 0;
        while (m_phase != ph && guard < 8) begin
            tick();
            guard++;
        end
    endtask

    // Full host handshake; REQ dropped the cycle after ACK, then one idle cycle.
    task automatic host_xfer(input string tag, input logic we, input logic [2:0] addr,
                             input logic [7:0] wdata, output logic [7:0] rd);
        int n = 0;
        bit got = 0;
        host_req   = 1'b1;
        host_we    = we;
        host_addr  = addr;
        host_wdata = wdata;
        while (!got && n < 8) begin
            tick();
            n++;
            got = last_ack;
        end
        chk({tag, "_ack_seen"}, 32'(got), 32'd1);
        chk({tag, "_latency_le4"}, 32'(n - 1 <= 4), 32'd1);
        rd       = last_rdata;
        host_req = 1'b0;
        host_we  = 1'b0;
        tick();
    endtask

    initial begin
        logic [7:0] rd, prior;
        int hwait;
        for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
        m_log_ok = 0; m_host_ok = 0; m_phase = M_WR;
        m_log_snap = '0; m_host_snap = '0;
        rst = 1'b1; en = 1'b1; log_wr = 1'b0; log_wptr = '0; log_wdata = '0; log_rptr = '0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0; host_freeze = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        m_phase = M_WR;

        // reset state and alternating write/read slots
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("turn_alternates", 32'(last_rw), 32'(i % 2 == 0));
            chk("read_alternates", 32'(last_rallow), 32'(i % 2 == 1));
        end

        // give every word a known value through host writes
        for (int i = 0; i < 8; i++) host_xfer("init", 1'b1, 3'(i), 8'($urandom), rd);

        // logger write then readback
        wait_phase(M_WR);
        log_wr = 1'b1; log_wptr = 3'd3; log_wdata = 8'hA5;
        tick();
        log_wr = 1'b0;
        wait_phase(M_WR);
        log_rptr = 3'd3;
        tick();
        tick();
        chk("log_read_a5", 32'(last_log), 32'hA5);
        chk("log_read_allow", 32'(last_rallow), 32'd1);

        // host write then host read
        host_xfer("hwr5", 1'b1, 3'd5, 8'h3C, rd);
        host_xfer("hrd5", 1'b0, 3'd5, 8'h00, rd);
        chk("host_read_3c", 32'(rd), 32'h3C);

        // freeze blocks the logger write
        prior = m_mem[2];
        host_freeze = 1'b1;
        wait_phase(M_WR);
        log_wr = 1'b1; log_wptr = 3'd2; log_wdata = 8'hFF;
        tick();
        chk("freeze_write_allow", 32'(last_wallow), 32'd0);
        log_wr = 1'b0; host_freeze = 1'b0;
        host_xfer("hrd2", 1'b0, 3'd2, 8'h00, rd);
        chk("freeze_prior_kept", 32'(rd), 32'(prior));

        // read-first collision in the logger write slot
        host_xfer("hwr4", 1'b1, 3'd4, 8'h22, rd);
        wait_phase(M_WR);
        log_wr = 1'b1; log_wptr = 3'd4; log_wdata = 8'h11; log_rptr = 3'd4;
        tick();
        log_wr = 1'b0;
        tick();
        chk("collision_old", 32'(last_log), 32'h22);
        wait_phase(M_WR);
        tick();
        tick();
        chk("collision_new", 32'(last_log), 32'h11);

        // host write and logger read of one address in the same round
        prior = m_mem[6];
        wait_phase(M_WR);
        log_rptr = 3'd6;
        host_req = 1'b1; host_we = 1'b1; host_addr = 3'd6; host_wdata = 8'h77;
        tick();
        tick();
        chk("same_round_pre_write", 32'(last_log), 32'(prior));
        tick();
        chk("same_round_ack", 32'(last_ack), 32'd1);
        host_req = 1'b0; host_we = 1'b0;
        tick();

        // enable low: slots continue, no logger write lands
        prior = m_mem[7];
        en = 1'b0;
        wait_phase(M_WR);
        log_wr = 1'b1; log_wptr = 3'd7; log_wdata = ~prior;
        tick();
        chk("disabled_turn", 32'(last_rw), 32'd0);
        log_wr = 1'b0;
        host_xfer("hrd7", 1'b0, 3'd7, 8'h00, rd);
        chk("disabled_no_write", 32'(rd), 32'(prior));
        en = 1'b1;

        // randomized traffic under the host handshake rules
        hwait = 0;
        for (int c = 0; c < 320; c++) begin
            en          = ($urandom_range(0, 7) != 0);
            host_freeze = ($urandom_range(0, 3) == 0);
            log_wr      = 1'($urandom);
            log_wptr    = 3'($urandom);
            log_wdata   = 8'($urandom);
            log_rptr    = 3'($urandom);
            if (host_req && last_ack) begin
                host_req = 1'b0; host_we = 1'b0;
            end else if (!host_req && c < 300 && $urandom_range(0, 2) == 0) begin
                host_req   = 1'b1;
                host_we    = 1'($urandom);
                host_addr  = 3'($urandom);
                host_wdata = 8'($urandom);
                hwait      = 0;
            end
            tick();
            if (host_req) begin
                if (last_ack) begin
                    chk("rand_host_latency", 32'(hwait <= 4), 32'd1);
                end else begin
                    hwait++;
                    if (hwait > 4) begin
                        chk("rand_host_timeout", 32'(hwait), 32'd4);
                        host_req = 1'b0; host_we = 1'b0;
                    end
                end
            end
        end
        en = 1'b1; log_wr = 1'b0; host_freeze = 1'b0; host_req = 1'b0; host_we = 1'b0;
        tick();

        // reset while a host read sits in its service slot
        wait_phase(M_WR);
        host_req = 1'b1; host_we = 1'b0; host_addr = 3'd5;
        tick();
        tick();
        rst = 1'b1; host_freeze = 1'b1;
        tick();
        chk("reset_no_ack", 32'(last_ack), 32'd0);
        rst = 1'b0; host_req = 1'b0;
        tick();
        chk("post_reset_turn", 32'(last_rw), 32'd1);
        chk("post_reset_wallow", 32'(last_wallow), 32'd0);
        chk("post_reset_rallow", 32'(last_rallow), 32'd0);
        chk("post_reset_ack", 32'(last_ack), 32'd0);
        chk("post_reset_log", 32'(last_log), 32'd0);
        chk("post_reset_rdata", 32'(last_rdata), 32'd0);
        host_freeze = 1'b0;
        host_xfer("rereq", 1'b0, 3'd5, 8'h00, rd);
        chk("rereq_data", 32'(rd), 32'(m_mem[5]));
        repeat (4) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
